// File: rtl/vdp_pkg.sv
// Shared VDP constants: active area, Game Gear LCD window and CRAM layout.
package vdp_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd256;
  localparam logic [9:0] V_ACTIVE = 10'd192;

  localparam logic [9:0] GG_X0    = 10'd48;
  localparam logic [9:0] GG_Y0    = 10'd24;
  localparam logic [9:0] GG_W     = 10'd160;
  localparam logic [9:0] GG_H     = 10'd144;
  localparam logic [9:0] GG_X_END = GG_X0 + GG_W;
  localparam logic [9:0] GG_Y_END = GG_Y0 + GG_H;

  localparam int unsigned CRAM_ENTRIES = 32;
  localparam int unsigned CRAM_R_OFS   = 0;
  localparam int unsigned CRAM_G_OFS   = 4;
  localparam int unsigned CRAM_B_OFS   = 8;

  localparam logic SPR_PALETTE_BIT = 1'b1;

  typedef logic [4:0]  cram_idx_t;
  typedef logic [11:0] cram_word_t;

endpackage

// File: rtl/vdp_cram.sv
// Game Gear colour RAM: 32 x 12-bit entries written as even/odd byte pairs, one registered read.
module vdp_cram
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic [5:0] addr_i,
  input  logic [7:0] data_i,
  input  cram_idx_t  rd_idx_i,
  output cram_word_t rd_data_o
);

  cram_word_t mem_q [CRAM_ENTRIES];
  cram_word_t mem_d [CRAM_ENTRIES];
  logic [7:0] latch_q, latch_d;
  cram_word_t rd_data_q, rd_data_d;

  always_comb begin
    mem_d   = mem_q;
    latch_d = latch_q;
    if (wr_i) begin
      if (!addr_i[0]) begin
        latch_d = data_i;
      end else begin
        mem_d[addr_i[5:1]] = {data_i[3:0], latch_q};
      end
    end
  end

  // Read uses the pre-write contents, so a same-cycle write is seen one cycle later.
  always_comb rd_data_d = mem_q[rd_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CRAM_ENTRIES; i++) mem_q[i] <= '0;
      latch_q   <= '0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      latch_q   <= latch_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vdp_color_mixer.sv
// Final VDP pixel stage: bg/sprite arbitration, blanking, backdrop and CRAM lookup (2-clock pipe).
// Define VDP_GG_WINDOW_EN to restrict pixel_valid to the Game Gear LCD window and zero RGB outside it.
module vdp_color_mixer
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] y,
  input  logic [5:0] bg_color,
  input  logic       bg_priority,
  input  logic [3:0] spr_color,
  input  logic [3:0] backdrop_color,
  input  logic       mask_col0,
  input  logic       display_en,
  input  logic       cram_wr,
  input  logic [5:0] cram_addr,
  input  logic [7:0] cram_data,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       pixel_valid
);

  cram_idx_t  idx_d, idx_q;
  logic       win_d, win_q;
  logic       pixel_valid_d, pixel_valid_q;
  logic       active, bg_opaque, spr_wins;
  cram_word_t rd_data, rgb;
  logic       unused_bg0;

  assign unused_bg0 = bg_color[0];

  always_comb begin
    active    = (pixel_x < H_ACTIVE) && (y < V_ACTIVE);
    bg_opaque = (bg_color[4:1] != 4'd0);
    spr_wins  = (spr_color != 4'd0) && !(bg_priority && bg_opaque);
    if (!active || !display_en || (mask_col0 && (pixel_x < 10'd8))) begin
      idx_d = {SPR_PALETTE_BIT, backdrop_color};
    end else if (spr_wins) begin
      idx_d = {SPR_PALETTE_BIT, spr_color};
    end else begin
      idx_d = bg_color[5:1];
    end
  end

  always_comb begin
`ifdef VDP_GG_WINDOW_EN
    win_d = (pixel_x >= GG_X0) && (pixel_x < GG_X_END) && (y >= GG_Y0) && (y < GG_Y_END);
`else
    win_d = active;
`endif
    pixel_valid_d = win_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q         <= '0;
      win_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      win_q         <= win_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  vdp_cram u_cram (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (cram_wr),
    .addr_i    (cram_addr),
    .data_i    (cram_data),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_data)
  );

  // Both operands are registered, so the output stays glitch-free and fully 2-clock aligned.
  always_comb begin
`ifdef VDP_GG_WINDOW_EN
    rgb = pixel_valid_q ? rd_data : '0;
`else
    rgb = rd_data;
`endif
  end

  assign red         = rgb[CRAM_R_OFS +: 4];
  assign green       = rgb[CRAM_G_OFS +: 4];
  assign blue        = rgb[CRAM_B_OFS +: 4];
  assign pixel_valid = pixel_valid_q;

endmodule
